// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, responder states and the bit-order
// helper that both the master and the slave use to pick the first bit of a word.
package spi_pkg;

  localparam logic [1:0] MODE00 = 2'b00;
  localparam logic [1:0] MODE01 = 2'b01;
  localparam logic [1:0] MODE10 = 2'b10;
  localparam logic [1:0] MODE11 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } slave_state_t;

  // Word position of the cnt-th bit on the wire.
  function automatic int bit_index(input int cnt, input bit lsb_first, input int data_width);
    return lsb_first ? cnt : (data_width - 1 - cnt);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by an edge register,
// giving the synchronized level and single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder in the local clk domain: oversamples sck/cs/mosi, returns the
// shadowed tx word on miso and presents each complete rx word with a valid pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int         DATA_WIDTH = 10,
  parameter logic [1:0] MODE       = MODE00,
  parameter logic       LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_abort
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = $clog2(DATA_WIDTH + 1);
  localparam int   FIRST_IDX = bit_index(0, LSB_FIRST, DATA_WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

  logic w_sck_level_unused;
  logic w_sck_rise, w_sck_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sck),
    .o_sync  (w_sck_level_unused),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cs),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // mosi is only ever read on an sck edge, so it needs no edge register.
  logic r_mosi_meta, r_mosi_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b1;
      r_mosi_sync <= 1'b1;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_lead        = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail       = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead  : w_trail;

  slave_state_t          r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_tx_shadow, w_tx_shadow_next;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_next;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_next;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_next;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic                  r_miso, w_miso_next;
  logic                  r_rx_valid, w_rx_valid_next;
  logic                  r_abort, w_abort_next;
  logic [DATA_WIDTH-1:0] w_tx_src, w_tx_shifted, w_rx_shifted;

  assign w_tx_src     = tx_load ? tx_data : r_tx_shadow;
  assign w_tx_shifted = LSB_FIRST ? {1'b1, r_tx_shift[DATA_WIDTH-1:1]}
                                  : {r_tx_shift[DATA_WIDTH-2:0], 1'b1};
  assign w_rx_shifted = LSB_FIRST ? {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]}
                                  : {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tx_shadow <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tx_shadow <= w_tx_shadow_next;
      r_tx_shift  <= w_tx_shift_next;
      r_rx_shift  <= w_rx_shift_next;
      r_rx_data   <= w_rx_data_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_miso      <= w_miso_next;
      r_rx_valid  <= w_rx_valid_next;
      r_abort     <= w_abort_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_tx_shadow_next = w_tx_src;
    w_tx_shift_next  = r_tx_shift;
    w_rx_shift_next  = r_rx_shift;
    w_rx_data_next   = r_rx_data;
    w_bit_cnt_next   = r_bit_cnt;
    w_miso_next      = r_miso;
    w_rx_valid_next  = 1'b0;
    w_abort_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next    = ST_ACTIVE;
          w_tx_shift_next = w_tx_src;
          w_bit_cnt_next  = '0;
          if (!CPHA) w_miso_next = w_tx_src[FIRST_IDX];
        end
      end
      ST_ACTIVE: begin
        // With CPHA=1 the first leading edge presents bit 0 without shifting.
        if (w_shift_edge && (r_bit_cnt < CNT_FULL)) begin
          if (CPHA && (r_bit_cnt == '0)) begin
            w_miso_next = r_tx_shift[FIRST_IDX];
          end else begin
            w_tx_shift_next = w_tx_shifted;
            w_miso_next     = w_tx_shifted[FIRST_IDX];
          end
        end
        if (w_sample_edge && (r_bit_cnt < CNT_FULL)) begin
          w_rx_shift_next = w_rx_shifted;
          w_bit_cnt_next  = r_bit_cnt + 1'b1;
          if (w_bit_cnt_next == CNT_FULL) begin
            w_rx_data_next  = w_rx_shifted;
            w_rx_valid_next = 1'b1;
          end
        end
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
          w_miso_next  = 1'b1;
          w_abort_next = (w_bit_cnt_next != CNT_FULL);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign miso        = r_miso;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = ~w_cs_sync;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives five instances (MODE00
// MSB-first plus all four modes LSB-first) and checks words against a frame model.
module tb_spi_slave;

  localparam int N = 5;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck_v      [N];
  logic       cs_v       [N];
  logic       mosi_v     [N];
  logic       miso_v     [N];
  logic [9:0] tx_data_v  [N];
  logic       tx_load_v  [N];
  logic [9:0] rx_data_v  [N];
  logic       rx_valid_v [N];
  logic       busy_v     [N];
  logic       abort_v    [N];

  int total = 0;
  int bad   = 0;
  int valid_cnt [N] = '{default: 0};
  int abort_cnt [N] = '{default: 0};
  logic [9:0] shadow_m [N];
  logic [9:0] rx_m     [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam logic [1:0] M = (gi == 0) ? 2'b00 : 2'(gi - 1);
    localparam logic       L = (gi != 0);
    spi_slave #(.DATA_WIDTH(10), .MODE(M), .LSB_FIRST(L)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sck         (sck_v[gi]),
      .cs          (cs_v[gi]),
      .mosi        (mosi_v[gi]),
      .miso        (miso_v[gi]),
      .tx_data     (tx_data_v[gi]),
      .tx_load     (tx_load_v[gi]),
      .rx_data     (rx_data_v[gi]),
      .rx_valid    (rx_valid_v[gi]),
      .busy        (busy_v[gi]),
      .frame_abort (abort_v[gi])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rx_valid_v[i]) valid_cnt[i]++;
      if (abort_v[i])    abort_cnt[i]++;
    end
  end

  function automatic logic [1:0] mode_of(input int i);
    return (i == 0) ? 2'b00 : 2'(i - 1);
  endfunction

  function automatic logic lsb_of(input int i);
    return (i != 0);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int inst, input logic [9:0] val);
    tx_data_v[inst] = val;
    tx_load_v[inst] = 1'b1;
    clks(1);
    tx_load_v[inst] = 1'b0;
    shadow_m[inst]  = val;
  endtask

  // Master side of one frame. end_mode: 0 = normal deselect, 1 = leave cs low,
  // 2 = raise cs together with the last leading edge (CPHA=0 only).
  task automatic frame(input int inst, input logic [9:0] word, input int nbits,
                       input int load_at, input logic [9:0] load_val,
                       input int end_mode, output logic [9:0] got);
    logic [1:0]  m;
    logic        cpol, cpha, lsb, last;
    logic [12:0] bits;
    m    = mode_of(inst);
    cpol = m[1];
    cpha = m[0];
    lsb  = lsb_of(inst);
    for (int k = 0; k < 13; k++)
      bits[k] = (k < 10) ? word[lsb ? k : 9 - k] : 1'($urandom_range(0, 1));
    got = '0;
    cs_v[inst] = 1'b0;
    if (!cpha) mosi_v[inst] = bits[0];
    if (load_at == -2) begin
      clks(2);
      tx_data_v[inst] = load_val;
      tx_load_v[inst] = 1'b1;
      clks(1);
      tx_load_v[inst] = 1'b0;
      clks(H - 3);
    end else begin
      clks(H);
    end
    chk("busy_active", 32'(busy_v[inst]), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        if (k < 10) got[lsb ? k : 9 - k] = miso_v[inst];
        else chk("miso_hold", 32'(miso_v[inst]), 32'(got[lsb ? 9 : 0]));
      end
      if (cpha) mosi_v[inst] = bits[k];
      last = (end_mode == 2) && (k == nbits - 1);
      if (last) cs_v[inst] = 1'b1;
      sck_v[inst] = ~cpol;
      if (load_at == k) begin
        tx_data_v[inst] = load_val;
        tx_load_v[inst] = 1'b1;
        clks(1);
        tx_load_v[inst] = 1'b0;
        clks(H - 1);
      end else begin
        clks(H);
      end
      if (last) break;
      if (cpha) begin
        if (k < 10) got[lsb ? k : 9 - k] = miso_v[inst];
        else chk("miso_hold", 32'(miso_v[inst]), 32'(got[lsb ? 9 : 0]));
      end
      if (!cpha) mosi_v[inst] = bits[k + 1];
      sck_v[inst] = cpol;
      clks(H);
    end
    if (end_mode == 2) begin
      sck_v[inst] = cpol;
      clks(H);
      chk("miso_idle", 32'(miso_v[inst]), 32'd1);
      chk("busy_idle", 32'(busy_v[inst]), 32'd0);
    end else if (end_mode == 0) begin
      cs_v[inst] = 1'b1;
      clks(3);
      chk("miso_idle_3clk", 32'(miso_v[inst]), 32'd1);
      clks(H);
      chk("busy_idle", 32'(busy_v[inst]), 32'd0);
    end
  endtask

  task automatic xfer(input int inst, input logic [9:0] word, input int nbits,
                      input int load_at, input logic [9:0] load_val, input int end_mode);
    int         v0, a0;
    bit         complete;
    logic [9:0] exp_tx, got;
    v0       = valid_cnt[inst];
    a0       = abort_cnt[inst];
    exp_tx   = (load_at == -2) ? load_val : shadow_m[inst];
    complete = (nbits >= 10);
    frame(inst, word, nbits, load_at, load_val, end_mode, got);
    if (load_at != -1) shadow_m[inst] = load_val;
    if (complete) rx_m[inst] = word;
    if (end_mode != 1) begin
      chk("rx_valid_count", 32'(valid_cnt[inst] - v0), complete ? 32'd1 : 32'd0);
      chk("abort_count", 32'(abort_cnt[inst] - a0), complete ? 32'd0 : 32'd1);
      chk("rx_data", 32'(rx_data_v[inst]), 32'(rx_m[inst]));
      if (complete) chk("miso_word", 32'(got), 32'(exp_tx));
    end
    $display("xfer inst=%0d mode=%0d lsb=%0d bits=%0d mosi=%h miso=%h rx=%h",
             inst, mode_of(inst), lsb_of(inst), nbits, word, got, rx_data_v[inst]);
  endtask

  task automatic check_reset(input int inst, input string tag);
    chk({tag, "_miso"},  32'(miso_v[inst]),     32'd1);
    chk({tag, "_rx"},    32'(rx_data_v[inst]),  32'd0);
    chk({tag, "_valid"}, 32'(rx_valid_v[inst]), 32'd0);
    chk({tag, "_busy"},  32'(busy_v[inst]),     32'd0);
    chk({tag, "_abort"}, 32'(abort_v[inst]),    32'd0);
  endtask

  task automatic idle_lines();
    for (int i = 0; i < N; i++) begin
      logic [1:0] m;
      m = mode_of(i);
      sck_v[i]     = m[1];
      cs_v[i]      = 1'b1;
      mosi_v[i]    = 1'b1;
      tx_load_v[i] = 1'b0;
      tx_data_v[i] = '0;
      shadow_m[i]  = '0;
      rx_m[i]      = '0;
    end
  endtask

  initial begin
    logic [9:0] w;
    rst_n = 1'b0;
    idle_lines();
    clks(4);
    for (int i = 0; i < N; i++) check_reset(i, "reset");
    $display("reset checked on %0d instances", N);
    rst_n = 1'b1;
    clks(H);

    load(0, 10'h2A5);
    xfer(0, 10'h15A, 10, -1, '0, 0);

    for (int i = 1; i < N; i++) begin
      load(i, 10'h001);
      xfer(i, 10'h001, 10, -1, '0, 0);
    end

    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (r != 1) load(i, 10'($urandom));
        xfer(i, 10'($urandom), 10, -1, '0, 0);
      end
    end

    xfer(0, 10'($urandom), 4, -1, '0, 0);

    load(0, 10'h000);
    xfer(0, 10'($urandom), 10, 5, 10'h3FF, 0);
    xfer(0, 10'($urandom), 10, -1, '0, 0);

    xfer(0, 10'($urandom), 12, -1, '0, 0);
    xfer(3, 10'($urandom), 12, -1, '0, 0);

    xfer(0, 10'($urandom), 10, -2, 10'($urandom), 0);
    xfer(4, 10'($urandom), 10, -2, 10'($urandom), 0);

    xfer(0, 10'($urandom), 10, -1, '0, 2);

    load(0, 10'($urandom));
    xfer(0, 10'($urandom), 5, -1, '0, 1);
    rst_n = 1'b0;
    #1;
    check_reset(0, "reset_mid");
    $display("reset applied mid-frame on inst=0");
    idle_lines();
    clks(4);
    rst_n = 1'b1;
    clks(H);
    w = 10'($urandom);
    xfer(0, w, 10, -1, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
